instr_fetch: RTL

Instruction fetch stage for the RV32I core, directly upstream of the instruction decoder. It owns the program counter and fetches one 32-bit word at a time from instruction memory over a request/response interface that tolerates variable latency. It presents each fetched instruction, together with its PC, to decode/execute through a valid/ready handshake. It also applies branch and jump redirects, discarding any response that becomes stale because of a redirect.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instr_fetch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Holds the fetch FSM state encoding, the instruction width in bytes and the
// default reset vector used by instr_fetch.

package fetch_pkg;

  // Fetch FSM states.
  //   S_IDLE  : post-reset, one cycle before the first request
  //   S_REQ   : request issued to instruction memory this cycle
  //   S_WAIT  : waiting for the response to the live request
  //   S_HOLD  : instruction presented downstream, waiting for instr_ready
  //   S_DRAIN : waiting for a response made stale by a redirect
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I instruction fetch stage with redirect and stale-response drain
//
// Owns the PC, issues one word fetch at a time to instruction memory and
// presents the fetched word with its PC to decode through a valid/ready
// handshake. Branch/jump redirects retarget the PC; any response that belongs
// to a superseded request is swallowed.
//
// Ports:
//   clk          core clock
//   reset        synchronous active-high reset
//   imem_req     fetch request (accepted by memory in the same cycle)
//   imem_addr    request byte address, pc while imem_req=1, else 0
//   imem_rvalid  response valid
//   imem_rdata   response instruction word
//   redirect     taken branch / jump from execute
//   redirect_pc  redirect target, low two bits forced to zero
//   instr_valid  instr / instr_pc / instr_pc4 valid (only in S_HOLD)
//   instr_ready  downstream accepts the instruction
//   instr        fetched instruction
//   instr_pc     address of instr
//   instr_pc4    instr_pc + 4 (link value)

module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  instr_pc4_q, instr_pc4_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;

  // Single adder shared by the link value capture and the sequential PC step.
  // Wraps modulo 2^32 by construction.
  assign pc_plus4        = pc_q + 32'(INSTR_BYTES);
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_pc4_d = instr_pc4_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) begin
          pc_d = redirect_target;
        end
      end

      S_REQ: begin
        // The request for the old pc still goes out this cycle, so a redirect
        // here leaves one stale response in flight.
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_target;
          // If the response lands together with the redirect it is already
          // consumed, so nothing is left to drain.
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          instr_d     = imem_rdata;
          instr_pc_d  = pc_q;
          instr_pc4_d = pc_plus4;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        // Redirect wins over ready: the held instruction is on the wrong path.
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (instr_ready) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC & ~32'h0000_0003;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instr_pc4_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_pc4_q <= instr_pc4_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output
  // combinationally.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = (state_q == S_REQ) ? pc_q : 32'h0000_0000;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_pc4   = instr_pc4_q;

endmodule : instr_fetch
